// File: rtl/ysyx_23060236_hazard_ctrl.sv
// RAW hazard scoreboard between decode and execute for the RV32E pipeline.
// Tracks in-flight writes per architectural register, blocks dependent or
// saturating issues, forwards the retiring writeback value when it clears the
// last pending write, undoes killed issues and keeps stall statistics.
module ysyx_23060236_hazard_ctrl #(
  parameter int NR_REG = 16,
  parameter int CNT_W  = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [3:0]          rs1,
  input  logic [3:0]          rs2,
  input  logic                need_rs1,
  input  logic                need_rs2,
  input  logic [3:0]          rd,
  input  logic                reg_wen,
  input  logic                exu_ready,
  output logic                issue_ready,
  input  logic [31:0]         src1_in,
  input  logic [31:0]         src2_in,
  output logic [31:0]         src1_out,
  output logic [31:0]         src2_out,
  input  logic                wb_valid,
  input  logic [3:0]          wb_rd,
  input  logic                wb_reg_wen,
  input  logic [31:0]         wb_val,
  input  logic                kill_valid,
  input  logic [3:0]          kill_rd,
  input  logic                kill_reg_wen,
  output logic                hazard,
  output logic [NR_REG-1:0]   busy_vec,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         stall_events
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Next in-flight count: add the issue, remove writeback and kill, then
  // clamp into [0, MAX] so a stray retire on an idle register cannot wrap.
  function automatic logic [CNT_W-1:0] cnt_next(
    input logic [CNT_W-1:0] cur,
    input logic             inc,
    input logic             dec_wb,
    input logic             dec_k
  );
    logic signed [CNT_W+1:0] sum;
    sum = $signed({2'b00, cur})
        + $signed({{(CNT_W+1){1'b0}}, inc})
        - $signed({{(CNT_W+1){1'b0}}, dec_wb})
        - $signed({{(CNT_W+1){1'b0}}, dec_k});
    if (sum[CNT_W+1]) begin
      return '0;
    end else if (sum > $signed({2'b00, CNT_MAX})) begin
      return CNT_MAX;
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  // A source stalls while a write to it remains pending after this cycle's
  // writeback; a single pending write retiring now is resolved by forwarding.
  function automatic logic src_blocked(
    input logic             need,
    input logic [3:0]       r,
    input logic [CNT_W-1:0] cnt,
    input logic             hit
  );
    return need & (r != 4'd0) & ((cnt > CNT_ONE) | ((cnt == CNT_ONE) & ~hit));
  endfunction

  // Forward only when the retiring write is the sole one outstanding; with
  // more pending, a younger write still owns the register.
  function automatic logic [31:0] fwd_sel(
    input logic [CNT_W-1:0] cnt,
    input logic             hit,
    input logic [31:0]      wbv,
    input logic [31:0]      rf
  );
    return ((cnt == CNT_ONE) & hit) ? wbv : rf;
  endfunction

  logic [CNT_W-1:0]  cnt_p1 [NR_REG];
  logic              hazard_q;

  logic [NR_REG-1:0] wb_hit_vec;
  logic [NR_REG-1:0] kill_vec;
  logic [NR_REG-1:0] inc_vec;
  logic              blk1;
  logic              blk2;
  logic              sat;
  logic              issue_fire;
  logic              stall_now;

  // Per-register decode of writeback, kill and issue events (x0 excluded).
  always_comb begin
    wb_hit_vec = '0;
    kill_vec   = '0;
    inc_vec    = '0;
    for (int r = 1; r < NR_REG; r++) begin
      wb_hit_vec[r] = wb_valid & wb_reg_wen & (wb_rd == 4'(r));
      kill_vec[r]   = kill_valid & kill_reg_wen & (kill_rd == 4'(r));
      inc_vec[r]    = issue_fire & reg_wen & (rd == 4'(r));
    end
  end

  // Issue decision and operand forwarding, all same-cycle.
  always_comb begin
    blk1        = src_blocked(need_rs1, rs1, cnt_p1[rs1], wb_hit_vec[rs1]);
    blk2        = src_blocked(need_rs2, rs2, cnt_p1[rs2], wb_hit_vec[rs2]);
    sat         = reg_wen & (rd != 4'd0) & (cnt_p1[rd] == CNT_MAX);
    hazard      = issue_valid & (blk1 | blk2 | sat);
    issue_ready = ~hazard & exu_ready & ~kill_valid;
    issue_fire  = issue_valid & issue_ready;
    stall_now   = issue_valid & hazard;
    src1_out    = fwd_sel(cnt_p1[rs1], wb_hit_vec[rs1], wb_val, src1_in);
    src2_out    = fwd_sel(cnt_p1[rs2], wb_hit_vec[rs2], wb_val, src2_in);
  end

  // Busy view of the scoreboard; x0 is never busy.
  always_comb begin
    busy_vec    = '0;
    for (int r = 1; r < NR_REG; r++) begin
      busy_vec[r] = |cnt_p1[r];
    end
  end

  // ---- stage boundary: scoreboard counters, visible the cycle after the edge
  always_ff @(posedge clock) begin
    cnt_p1[0] <= '0;
    for (int r = 1; r < NR_REG; r++) begin
      if (reset) begin
        cnt_p1[r] <= '0;
      end else begin
        cnt_p1[r] <= cnt_next(cnt_p1[r], inc_vec[r], wb_hit_vec[r], kill_vec[r]);
      end
    end
  end

  // ---- stage boundary: stall statistics, wrapping modulo 2^32
  always_ff @(posedge clock) begin
    if (reset) begin
      hazard_q     <= 1'b0;
      stall_cycles <= '0;
      stall_events <= '0;
    end else begin
      hazard_q <= stall_now;
      if (stall_now) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (stall_now & ~hazard_q) begin
        stall_events <= stall_events + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_hazard_ctrl.sv
// Directed bench for the hazard scoreboard: a register-count model checked on
// every falling edge, plus hand-computed literal expectations per scenario.
module tb_ysyx_23060236_hazard_ctrl;

  localparam int NR_REG = 16;
  localparam int CNT_W  = 2;
  localparam int MAXC   = (1 << CNT_W) - 1;

  localparam int K_BUSY = 0;
  localparam int K_HAZ  = 1;
  localparam int K_RDY  = 2;
  localparam int K_S1   = 3;
  localparam int K_S2   = 4;
  localparam int K_SC   = 5;
  localparam int K_SE   = 6;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [3:0]  rs1, rs2, rd;
  logic        need_rs1, need_rs2, reg_wen, exu_ready;
  logic        issue_ready;
  logic [31:0] src1_in, src2_in, src1_out, src2_out;
  logic        wb_valid, wb_reg_wen;
  logic [3:0]  wb_rd;
  logic [31:0] wb_val;
  logic        kill_valid, kill_reg_wen;
  logic [3:0]  kill_rd;
  logic        hazard;
  logic [15:0] busy_vec;
  logic [31:0] stall_cycles, stall_events;

  ysyx_23060236_hazard_ctrl #(.NR_REG(NR_REG), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid),
    .rs1(rs1), .rs2(rs2), .need_rs1(need_rs1), .need_rs2(need_rs2),
    .rd(rd), .reg_wen(reg_wen), .exu_ready(exu_ready), .issue_ready(issue_ready),
    .src1_in(src1_in), .src2_in(src2_in), .src1_out(src1_out), .src2_out(src2_out),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_wen(wb_reg_wen), .wb_val(wb_val),
    .kill_valid(kill_valid), .kill_rd(kill_rd), .kill_reg_wen(kill_reg_wen),
    .hazard(hazard), .busy_vec(busy_vec),
    .stall_cycles(stall_cycles), .stall_events(stall_events)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_vec;
  int          n_miss;
  int          cyc_no;

  // model state: outstanding writes per register and statistics
  int          m_cnt [NR_REG];
  int          m_cycles;
  int          m_events;
  bit          m_prev;
  bit          m_valid;

  // per-cycle expectations derived from the model
  bit          e_haz, e_rdy, e_fire, e_stall;
  logic [31:0] e_s1, e_s2;
  logic [15:0] e_busy;
  int          left1, left2, nv;
  bit          wb_res, blk1, blk2, satm;

  // literal expectations posted by the stimulus for the current cycle
  bit          lit_en  [7];
  logic [31:0] lit_val [7];
  string       lit_name [7] = '{"lit_busy_vec", "lit_hazard", "lit_issue_ready",
                                "lit_src1_out", "lit_src2_out",
                                "lit_stall_cycles", "lit_stall_events"};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at t=%0t: got %h, required %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] get_act(input int k);
    case (k)
      K_BUSY:  return 32'(busy_vec);
      K_HAZ:   return 32'(hazard);
      K_RDY:   return 32'(issue_ready);
      K_S1:    return src1_out;
      K_S2:    return src2_out;
      K_SC:    return stall_cycles;
      default: return stall_events;
    endcase
  endfunction

  // Compare DUT against the model each falling edge, then advance the model.
  always @(negedge clock) begin
    wb_res = wb_valid && wb_reg_wen && (wb_rd != 4'd0);
    left1  = m_cnt[rs1] - ((wb_res && wb_rd == rs1) ? 1 : 0);
    left2  = m_cnt[rs2] - ((wb_res && wb_rd == rs2) ? 1 : 0);
    blk1   = need_rs1 && (rs1 != 4'd0) && (left1 > 0);
    blk2   = need_rs2 && (rs2 != 4'd0) && (left2 > 0);
    satm   = reg_wen && (rd != 4'd0) && (m_cnt[rd] == MAXC);
    e_haz  = issue_valid && (blk1 || blk2 || satm);
    e_rdy  = !e_haz && exu_ready && !kill_valid;
    e_fire = issue_valid && e_rdy;
    e_stall = issue_valid && e_haz;
    e_s1   = (m_cnt[rs1] == 1 && wb_res && wb_rd == rs1) ? wb_val : src1_in;
    e_s2   = (m_cnt[rs2] == 1 && wb_res && wb_rd == rs2) ? wb_val : src2_in;
    for (int i = 0; i < NR_REG; i++) e_busy[i] = (m_cnt[i] > 0);

    if (m_valid) begin
      chk("hazard", 32'(hazard), 32'(e_haz));
      chk("issue_ready", 32'(issue_ready), 32'(e_rdy));
      chk("src1_out", src1_out, e_s1);
      chk("src2_out", src2_out, e_s2);
      chk("busy_vec", 32'(busy_vec), 32'(e_busy));
      chk("stall_cycles", stall_cycles, 32'(m_cycles));
      chk("stall_events", stall_events, 32'(m_events));
    end
    for (int k = 0; k < 7; k++) begin
      if (lit_en[k]) chk(lit_name[k], get_act(k), lit_val[k]);
    end

    if (reset) begin
      for (int i = 0; i < NR_REG; i++) m_cnt[i] = 0;
      m_cycles = 0;
      m_events = 0;
      m_prev   = 1'b0;
      m_valid  = 1'b1;
    end else begin
      for (int r = 1; r < NR_REG; r++) begin
        nv = m_cnt[r];
        if (e_fire && reg_wen && rd == 4'(r)) nv++;
        if (wb_res && wb_rd == 4'(r)) nv--;
        if (kill_valid && kill_reg_wen && kill_rd == 4'(r)) nv--;
        m_cnt[r] = (nv < 0) ? 0 : nv;
      end
      if (e_stall) m_cycles++;
      if (e_stall && !m_prev) m_events++;
      m_prev = e_stall;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
    cyc_no++;
    reset = 1'b0;
    issue_valid = 1'b0; rs1 = 4'd0; rs2 = 4'd0; need_rs1 = 1'b0; need_rs2 = 1'b0;
    rd = 4'd0; reg_wen = 1'b0; exu_ready = 1'b1;
    src1_in = 32'h1000_0000 + 32'(cyc_no);
    src2_in = 32'h2000_0000 + 32'(cyc_no);
    wb_valid = 1'b0; wb_rd = 4'd0; wb_reg_wen = 1'b0;
    wb_val = 32'hCAFE_0000 + 32'(cyc_no);
    kill_valid = 1'b0; kill_rd = 4'd0; kill_reg_wen = 1'b0;
    for (int k = 0; k < 7; k++) lit_en[k] = 1'b0;
  endtask

  task automatic lit(input int k, input logic [31:0] v);
    lit_en[k]  = 1'b1;
    lit_val[k] = v;
  endtask

  task automatic iss(input logic [3:0] r);
    issue_valid = 1'b1; rd = r; reg_wen = 1'b1;
  endtask

  task automatic use1(input logic [3:0] r);
    issue_valid = 1'b1; need_rs1 = 1'b1; rs1 = r;
  endtask

  task automatic use2(input logic [3:0] r);
    issue_valid = 1'b1; need_rs2 = 1'b1; rs2 = r;
  endtask

  task automatic wb(input logic [3:0] r, input logic [31:0] v);
    wb_valid = 1'b1; wb_reg_wen = 1'b1; wb_rd = r; wb_val = v;
  endtask

  task automatic kill(input logic [3:0] r);
    kill_valid = 1'b1; kill_reg_wen = 1'b1; kill_rd = r;
  endtask

  initial begin
    n_vec = 0; n_miss = 0; cyc_no = 0; m_valid = 1'b0;
    m_cycles = 0; m_events = 0; m_prev = 1'b0;
    for (int i = 0; i < NR_REG; i++) m_cnt[i] = 0;
    for (int k = 0; k < 7; k++) begin lit_en[k] = 1'b0; lit_val[k] = '0; end
    reset = 1'b1; issue_valid = 1'b0; rs1 = 4'd0; rs2 = 4'd0; need_rs1 = 1'b0;
    need_rs2 = 1'b0; rd = 4'd0; reg_wen = 1'b0; exu_ready = 1'b1;
    src1_in = '0; src2_in = '0; wb_valid = 1'b0; wb_rd = 4'd0; wb_reg_wen = 1'b0;
    wb_val = '0; kill_valid = 1'b0; kill_rd = 4'd0; kill_reg_wen = 1'b0;
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b1; lit(K_BUSY, 0); lit(K_SC, 0); lit(K_SE, 0);

    // producer of x5, then a stalled consumer, then wb resolves it
    cyc(); iss(4'd5); lit(K_RDY, 1); lit(K_BUSY, 0);
    cyc(); use1(4'd5); lit(K_BUSY, 32'h20); lit(K_HAZ, 1); lit(K_RDY, 0); lit(K_SC, 0);
    cyc(); use1(4'd5); lit(K_SC, 1); lit(K_SE, 1);
    cyc(); use1(4'd5); lit(K_SC, 2);
    cyc(); use1(4'd5); wb(4'd5, 32'hDEADBEEF);
    lit(K_HAZ, 0); lit(K_S1, 32'hDEADBEEF); lit(K_RDY, 1); lit(K_SC, 3);
    cyc(); lit(K_BUSY, 0); lit(K_SE, 1);

    // two writes to x3 in flight: first wb does not clear the rs2 hazard
    cyc(); iss(4'd3);
    cyc(); iss(4'd3);
    cyc(); use2(4'd3); wb(4'd3, 32'h4444_4444); lit(K_BUSY, 32'h8); lit(K_HAZ, 1);
    cyc(); use2(4'd3); wb(4'd3, 32'h3333_3333); lit(K_HAZ, 0); lit(K_S2, 32'h3333_3333);
    cyc(); use2(4'd3); src2_in = 32'h2222_2222;
    lit(K_HAZ, 0); lit(K_S2, 32'h2222_2222); lit(K_BUSY, 0); lit(K_SC, 4); lit(K_SE, 2);

    // kill undoes the x7 issue and blocks issue in its cycle
    cyc(); iss(4'd7);
    cyc(); iss(4'd2); kill(4'd7); lit(K_RDY, 0); lit(K_HAZ, 0); lit(K_BUSY, 32'h80);
    cyc(); use1(4'd7); lit(K_BUSY, 0); lit(K_HAZ, 0); lit(K_RDY, 1);

    // saturation of x9 at MAX, relieved by one writeback
    cyc(); iss(4'd9);
    cyc(); iss(4'd9);
    cyc(); iss(4'd9);
    cyc(); iss(4'd9); lit(K_BUSY, 32'h200); lit(K_HAZ, 1); lit(K_RDY, 0);
    cyc(); iss(4'd9); wb(4'd9, 32'h9999_0000); lit(K_HAZ, 1);
    cyc(); iss(4'd9); lit(K_HAZ, 0); lit(K_RDY, 1); lit(K_BUSY, 32'h200);
    cyc(); wb(4'd9, 32'h9999_0001);
    cyc(); wb(4'd9, 32'h9999_0002);
    cyc(); wb(4'd9, 32'h9999_0003);
    cyc(); lit(K_BUSY, 0);

    // wb and kill together on x6, stray wb on idle x8, exu back-pressure
    cyc(); iss(4'd6);
    cyc(); iss(4'd6);
    cyc(); wb(4'd6, 32'h6666_0000); kill(4'd6); lit(K_BUSY, 32'h40);
    cyc(); wb(4'd8, 32'h8888_0000); lit(K_BUSY, 0);
    cyc(); iss(4'd10); exu_ready = 1'b0; lit(K_RDY, 0); lit(K_HAZ, 0); lit(K_BUSY, 0);
    cyc(); lit(K_BUSY, 0);

    // reset with a write in flight discards it
    cyc(); iss(4'd11);
    cyc(); reset = 1'b1; lit(K_BUSY, 32'h800);
    cyc(); lit(K_BUSY, 0); lit(K_SC, 0); lit(K_SE, 0);

    // x0 never tracked, then two separate 3-cycle stalls on x4
    for (int i = 0; i < 3; i++) begin
      cyc(); use1(4'd0); rd = 4'd0; reg_wen = 1'b1;
      lit(K_HAZ, 0); lit(K_RDY, 1); lit(K_BUSY, 0);
    end
    cyc(); iss(4'd4);
    for (int i = 0; i < 3; i++) begin cyc(); use1(4'd4); end
    cyc();
    for (int i = 0; i < 3; i++) begin cyc(); use1(4'd4); end
    cyc(); wb(4'd4, 32'h4040_4040);
    cyc(); lit(K_SC, 6); lit(K_SE, 2); lit(K_BUSY, 0);
    cyc();

    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ysyx_23060236_hazard_ctrl.md
Name: ysyx_23060236_hazard_ctrl

Overview:
Scoreboard-based RAW hazard controller for the RV32E in-order pipeline, between decode and execute.
- Keeps a per-register count of in-flight writes (x1..x15).
- Grants or stalls decode issue.
- Forwards the writeback value when it resolves the last pending write.
- Undoes squashed issues on branch-mispredict kill.
- Keeps stall statistics counters.

Parameters:
NR_REG, 16, architectural registers (index width 4; x0 never tracked)
CNT_W, 2, width of each in-flight counter; MAX = 2^CNT_W-1

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
issue_valid  in  1  decode holds a valid instruction
rs1  in  4  source register 1 index
rs2  in  4  source register 2 index
need_rs1  in  1  instruction reads rs1
need_rs2  in  1  instruction reads rs2
rd  in  4  destination index
reg_wen  in  1  instruction writes rd
exu_ready  in  1  execute stage can accept
issue_ready  out  1  issue permitted this cycle
src1_in  in  32  register-file read data for rs1
src2_in  in  32  register-file read data for rs2
src1_out  out  32  resolved rs1 operand
src2_out  out  32  resolved rs2 operand
wb_valid  in  1  writeback retiring this cycle
wb_rd  in  4  writeback destination
wb_reg_wen  in  1  writeback writes register
wb_val  in  32  writeback data
kill_valid  in  1  squash the instruction currently latched for execute
kill_rd  in  4  squashed instruction's rd
kill_reg_wen  in  1  squashed instruction's reg_wen
hazard  out  1  issue blocked by a dependency
busy_vec  out  16  bit i = (cnt[i] != 0); bit 0 always 0
stall_cycles  out  32  cycles with issue_valid & hazard
stall_events  out  32  rising edges of (issue_valid & hazard)

Behaviour:
Reset
- All cnt[i], busy_vec, stall_cycles and stall_events are 0.
- Internal hazard_q is 0.
- Reset mid-operation discards all in-flight state at the next edge.

wb_hit(r) = wb_valid & wb_reg_wen & (wb_rd == r) & (r != 0).

src_blocked(r, need) = need & (r != 0) & ((cnt[r] > 1) | (cnt[r] == 1 & ~wb_hit(r))).

sat = reg_wen & (rd != 0) & (cnt[rd] == MAX).

hazard (combinational)
- hazard = issue_valid & (src_blocked(rs1,need_rs1) | src_blocked(rs2,need_rs2) | sat).

issue_ready (combinational)
- issue_ready = ~hazard & exu_ready & ~kill_valid.
- issue_fire = issue_valid & issue_ready.

Forwarding (combinational)
- src1_out = (cnt[rs1] == 1 & wb_hit(rs1)) ? wb_val : src1_in; src2_out likewise.
- Forwarding never applies when cnt > 1, because the younger write is still pending.

Counter update, per register r != 0, at each clock edge
- inc = issue_fire & reg_wen & (rd == r)
- dec_wb = wb_hit(r)
- dec_k = kill_valid & kill_reg_wen & (kill_rd == r)
- cnt[r] <= cnt[r] + inc - dec_wb - dec_k
- Simultaneous issue and wb to the same r: count unchanged.
- wb and kill to the same r: decrement by 2.
- If the result would go below 0, it clamps to 0.
- Increment never exceeds MAX, because sat blocks issue at MAX.

x0
- cnt[0] is constant 0; writes, wb and kill targeting x0 are ignored.

Statistics
- stall_cycles += 1 on every cycle where issue_valid & hazard.
- hazard_q <= issue_valid & hazard.
- stall_events += 1 when (issue_valid & hazard) & ~hazard_q.
- Both counters wrap modulo 2^32.

Latency
- Scoreboard updates are visible one cycle after the edge.
- Hazard, forwarding and issue_ready are same-cycle combinational.

Test Plan:
1. Reset, then issue x5=... (rd=5, reg_wen=1, exu_ready=1) → busy_vec=0x0020. Next cycle, need_rs1, rs1=5, no wb → hazard=1, issue_ready=0, stall_cycles increments every cycle.
2. Same setup as test 1 with wb_valid=1, wb_rd=5, wb_val=0xDEADBEEF in the dependent cycle → hazard=0, src1_out=0xDEADBEEF, cnt[5] returns to 0 (the dependent instruction does not write x5).
3. Two issues to rd=3 back-to-back, then wb_rd=3 while a consumer needs rs2=3 → hazard=1 (cnt=2). After the second wb: cnt=0, hazard=0, src2_out=src2_in.
4. Issue rd=7, then kill_valid=1, kill_rd=7, kill_reg_wen=1 with issue_valid=1 the same cycle → issue_ready=0. Afterwards busy_vec[7]=0 and a consumer of x7 issues without stall.
5. CNT_W=2: three issues to rd=9 with no wb → cnt[9]=3. Fourth issue to rd=9 → hazard=1 by saturation. A wb to x9 lowers cnt to 2 and the issue proceeds.
6. rd=0 / rs1=0 with reg_wen=1, need_rs1=1 on consecutive issues → never busy, never stall. Two separate 3-cycle stalls → stall_events=2, stall_cycles=6.
